shared_mem_arbiter: RTL and testbench

- Parametrised successor to the per-port instruction/data memory tops: one shared word-addressed memory serving N_CH requesters (channel 0 = instruction fetch, channel 1 = data; more for future masters).
- Uses the same request / we_re / masking / valid handshake the core already drives.
- Adds multi-channel arbitration (round-robin or fixed priority), programmable wait states and out-of-range handling.
- Sits between the core and a single memory array, replacing the two separate memory tops.

---
 rtl/shared_mem_arbiter_if.sv | 27 ++
 rtl/shared_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_shared_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_mem_arbiter_if.sv
// rtl/shared_mem_arbiter_if.sv - requester-side bus bundle for the shared memory arbiter
interface shared_mem_arbiter_if #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [N_CH-1:0]          request;
  logic [N_CH-1:0]          we_re;
  logic [N_CH*ADDR_W-1:0]   address;
  logic [N_CH*DATA_W-1:0]   w_data;
  logic [N_CH*DATA_W/8-1:0] masking;
  logic [N_CH-1:0]          valid;
  logic [DATA_W-1:0]        r_data;
  logic                     busy;

  // Requesters (core side) drive the request bundle and observe completion.
  modport master (
    output request, we_re, address, w_data, masking,
    input  valid, r_data, busy
  );

  // The arbiter consumes requests and drives completion.
  modport slave (
    input  request, we_re, address, w_data, masking,
    output valid, r_data, busy
  );
endinterface

// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - N-channel arbiter in front of one word-addressed memory
module shared_mem_arbiter #(
  parameter int N_CH        = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1,
  parameter int RR_MODE     = 1
) (
  input  logic                clk,
  input  logic                rst,
  shared_mem_arbiter_if.slave bus
);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int NB     = DATA_W / 8;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CH_W-1:0]     r_ptr;
  logic [3:0]          r_cnt;
  logic [CH_W-1:0]     r_gnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [NB-1:0]       r_mask;
  logic [N_CH-1:0]     r_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_found;
  logic [CH_W-1:0]     w_grant;
  logic                w_access;
  logic [CH_W-1:0]     w_acc_gnt;
  logic                w_acc_we;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_data;
  logic [NB-1:0]       w_acc_mask;
  logic                w_in_range;
  logic [MEM_AW-1:0]   w_mem_idx;

  // Arbitration: scan from the round-robin pointer (or from 0 in fixed priority) for the first request.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!w_found && bus.request[(RR_MODE != 0) ? ((int'(r_ptr) + i) % N_CH) : i]) begin
        w_found = 1'b1;
        w_grant = CH_W'((RR_MODE != 0) ? ((int'(r_ptr) + i) % N_CH) : i);
      end
    end
  end

  // Access operands: live granted inputs on a zero-wait grant, otherwise the latched transaction.
  always_comb begin
    w_access   = ((r_state == S_IDLE) && w_found && (WAIT_CYCLES == 0)) ||
                 ((r_state == S_WAIT) && (r_cnt == 4'd1));
    w_acc_gnt  = r_gnt;
    w_acc_we   = r_we;
    w_acc_addr = r_addr;
    w_acc_data = r_wdata;
    w_acc_mask = r_mask;
    if (r_state == S_IDLE) begin
      w_acc_gnt  = w_grant;
      w_acc_we   = bus.we_re[w_grant];
      w_acc_addr = bus.address[w_grant*ADDR_W +: ADDR_W];
      w_acc_data = bus.w_data[w_grant*DATA_W +: DATA_W];
      w_acc_mask = bus.masking[w_grant*NB +: NB];
    end
    w_in_range = (32'(w_acc_addr) < DEPTH);
    w_mem_idx  = w_acc_addr[MEM_AW-1:0];
  end

  // Next-state logic for the IDLE -> WAIT -> RESP transaction sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_found) w_state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 4'd1) w_state_nxt = S_RESP;
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, transaction latch, wait counter, read data and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_valid <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= '0;
      if ((r_state == S_IDLE) && w_found) begin
        r_gnt   <= w_grant;
        r_we    <= bus.we_re[w_grant];
        r_addr  <= bus.address[w_grant*ADDR_W +: ADDR_W];
        r_wdata <= bus.w_data[w_grant*DATA_W +: DATA_W];
        r_mask  <= bus.masking[w_grant*NB +: NB];
        r_cnt   <= 4'(WAIT_CYCLES);
        if (RR_MODE != 0) r_ptr <= (w_grant == CH_W'(N_CH - 1)) ? '0 : w_grant + 1'b1;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        if (!w_acc_we) r_rdata <= w_in_range ? r_mem[w_mem_idx] : '0;
        r_valid[w_acc_gnt] <= 1'b1;
      end
    end
  end

  // Memory array: byte-lane writes on the access edge; contents survive reset, an asserted reset blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && w_access && w_acc_we && w_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (w_acc_mask[b]) r_mem[w_mem_idx][b*8 +: 8] <= w_acc_data[b*8 +: 8];
      end
    end
  end

  assign bus.valid  = r_valid;
  assign bus.r_data = r_rdata;
  assign bus.busy   = (r_state != S_IDLE);
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb/tb_shared_mem_arbiter.sv - self-checking bench for shared_mem_arbiter against a transaction-level model
module tb_shared_mem_arbiter;
  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_checks;
  int   n_err;

  // Instance A: round-robin, one wait state, 128 words. Instance B: fixed priority, three wait states, 256 words.
  int   depth_m [2] = '{128, 256};
  int   wc_m    [2] = '{1, 3};
  bit   rr_m    [2] = '{1'b1, 1'b0};
  int   ptr_m   [2];
  logic [31:0] last_rd_m [2];
  logic [31:0] mem_m [2][256];

  shared_mem_arbiter_if #(.N_CH(2), .ADDR_W(8), .DATA_W(32)) ifa ();
  shared_mem_arbiter_if #(.N_CH(2), .ADDR_W(8), .DATA_W(32)) ifb ();

  shared_mem_arbiter #(.N_CH(2), .ADDR_W(8), .DATA_W(32), .DEPTH(128), .WAIT_CYCLES(1), .RR_MODE(1))
    dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  shared_mem_arbiter #(.N_CH(2), .ADDR_W(8), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(3), .RR_MODE(0))
    dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input int ch, input logic req, input logic we,
                       input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    if (sel == 0) begin
      ifa.request[ch] = req; ifa.we_re[ch] = we; ifa.address[ch*8 +: 8] = a;
      ifa.w_data[ch*32 +: 32] = d; ifa.masking[ch*4 +: 4] = m;
    end else begin
      ifb.request[ch] = req; ifb.we_re[ch] = we; ifb.address[ch*8 +: 8] = a;
      ifb.w_data[ch*32 +: 32] = d; ifb.masking[ch*4 +: 4] = m;
    end
  endtask

  task automatic drive_req(input int sel, input int ch, input logic req);
    if (sel == 0) ifa.request[ch] = req;
    else ifb.request[ch] = req;
  endtask

  function automatic logic [1:0] get_valid(input int sel);
    return (sel == 0) ? ifa.valid : ifb.valid;
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? ifa.r_data : ifb.r_data;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? ifa.busy : ifb.busy;
  endfunction

  // Reference memory: returns the word a read must produce; applies writes with byte masks, drops out-of-range.
  function automatic logic [31:0] model_access(input int sel, input logic we, input logic [7:0] a,
                                               input logic [31:0] d, input logic [3:0] m);
    if (int'(a) >= depth_m[sel]) return 32'h0;
    if (we) begin
      for (int b = 0; b < 4; b++) if (m[b]) mem_m[sel][a][b*8 +: 8] = d[b*8 +: 8];
      return 32'h0;
    end
    return mem_m[sel][a];
  endfunction

  // Reference arbitration over the set of pending channels.
  function automatic int model_grant(input int sel, input logic [1:0] pend);
    for (int i = 0; i < 2; i++) begin
      int c;
      c = rr_m[sel] ? (ptr_m[sel] + i) % 2 : i;
      if (pend[c]) return c;
    end
    return 0;
  endfunction

  task automatic rand_op(input int sel, output logic we, output logic [7:0] a,
                         output logic [31:0] d, output logic [3:0] m);
    we = 1'($urandom_range(0, 1));
    d  = $urandom;
    m  = 4'($urandom_range(0, 15));
    a  = 8'($urandom_range(0, 7) * 16 + 5);
    if (sel == 0 && $urandom_range(0, 2) == 0) a = 8'($urandom_range(128, 255));
  endtask

  task automatic wait_valid(input int sel, input int wd_ch, output logic [1:0] v, output int lat);
    v = '0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      v = get_valid(sel);
      chk("valid_onehot0", 32'($countones(v) <= 1), 32'd1);
      if (wd_ch >= 0 && lat == 2) drive_req(sel, wd_ch, 1'b0);
      if (v != 0) break;
    end
  endtask

  // Track what the model expects after a completed grant g for op (we, a, d, m).
  task automatic complete(input int sel, input int g, input logic we, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] m);
    logic [31:0] exp_rd;
    exp_rd = model_access(sel, we, a, d, m);
    if (!we) last_rd_m[sel] = exp_rd;
    chk(we ? "rdata_hold" : "rdata", get_rdata(sel), last_rd_m[sel]);
    chk("busy_resp", 32'(get_busy(sel)), 32'd1);
    if (rr_m[sel]) ptr_m[sel] = (g + 1) % 2;
  endtask

  task automatic txn(input int sel, input int ch, input logic we, input logic [7:0] a,
                     input logic [31:0] d, input logic [3:0] m, input int wd, output logic [31:0] rd);
    logic [1:0] v;
    int lat;
    @(posedge clk); #1;
    drive(sel, ch, 1'b1, we, a, d, m);
    wait_valid(sel, wd, v, lat);
    chk("txn_valid", 32'(v), 32'(1 << ch));
    chk("txn_latency", 32'(lat), 32'(wc_m[sel] + 2));
    complete(sel, ch, we, a, d, m);
    rd = get_rdata(sel);
    drive_req(sel, ch, 1'b0);
    @(negedge clk);
    chk("txn_valid_drop", 32'(get_valid(sel)), 32'd0);
    chk("txn_busy_idle", 32'(get_busy(sel)), 32'd0);
  endtask

  task automatic contend(input int sel, input int n, input int refill_pct);
    logic [1:0]  pend;
    logic        p_we [2];
    logic [7:0]  p_a  [2];
    logic [31:0] p_d  [2];
    logic [3:0]  p_m  [2];
    logic [1:0]  v;
    int lat, g, served;
    served = 0;
    pend = 2'b11;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      rand_op(sel, p_we[c], p_a[c], p_d[c], p_m[c]);
      drive(sel, c, 1'b1, p_we[c], p_a[c], p_d[c], p_m[c]);
    end
    while (pend != 2'b00) begin
      g = model_grant(sel, pend);
      wait_valid(sel, -1, v, lat);
      chk("arb_grant", 32'(v), 32'(1 << g));
      chk("arb_latency", 32'(lat), 32'(wc_m[sel] + 2));
      complete(sel, g, p_we[g], p_a[g], p_d[g], p_m[g]);
      pend[g] = 1'b0;
      drive_req(sel, g, 1'b0);
      served++;
      if (served < n) begin
        if ($urandom_range(1, 100) <= refill_pct) begin
          rand_op(sel, p_we[g], p_a[g], p_d[g], p_m[g]);
          pend[g] = 1'b1;
          drive(sel, g, 1'b1, p_we[g], p_a[g], p_d[g], p_m[g]);
        end
        if (!pend[1-g] && $urandom_range(0, 1) == 1) begin
          rand_op(sel, p_we[1-g], p_a[1-g], p_d[1-g], p_m[1-g]);
          pend[1-g] = 1'b1;
          drive(sel, 1-g, 1'b1, p_we[1-g], p_a[1-g], p_d[1-g], p_m[1-g]);
        end
        if (pend == 2'b00) begin
          rand_op(sel, p_we[g], p_a[g], p_d[g], p_m[g]);
          pend[g] = 1'b1;
          drive(sel, g, 1'b1, p_we[g], p_a[g], p_d[g], p_m[g]);
        end
      end
    end
    @(negedge clk);
    chk("arb_busy_idle", 32'(get_busy(sel)), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  v;
    n_checks = 0;
    n_err = 0;
    ptr_m = '{0, 0};
    last_rd_m = '{32'h0, 32'h0};
    for (int s = 0; s < 2; s++) for (int w = 0; w < 256; w++) mem_m[s][w] = 32'h0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int s = 0; s < 2; s++) for (int c = 0; c < 2; c++) drive(s, c, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_valid", 32'(get_valid(s)), 32'd0);
      chk("reset_rdata", get_rdata(s), 32'h0);
      chk("reset_busy", 32'(get_busy(s)), 32'd0);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 8; k++) txn(s, k % 2, 1'b1, 8'(k * 16 + 5), $urandom, 4'hF, -1, rd);

    txn(0, 1, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, -1, rd);
    txn(0, 1, 1'b0, 8'h10, 32'h0, 4'h0, -1, rd);
    chk("deadbeef_read", rd, 32'hDEADBEEF);

    txn(0, 0, 1'b1, 8'h05, 32'h11223344, 4'hF, -1, rd);
    txn(0, 1, 1'b1, 8'h05, 32'hAABBCCDD, 4'b0101, -1, rd);
    txn(0, 0, 1'b0, 8'h05, 32'h0, 4'hF, -1, rd);
    chk("byte_mask_read", rd, 32'h11BB33DD);

    txn(0, 0, 1'b1, 8'h40, 32'hCAFEF00D, 4'hF, -1, rd);
    txn(0, 1, 1'b1, 8'hC0, 32'h12345678, 4'hF, -1, rd);
    txn(0, 1, 1'b0, 8'hC0, 32'h0, 4'h0, -1, rd);
    chk("oor_read_zero", rd, 32'h0);
    txn(0, 0, 1'b0, 8'h40, 32'h0, 4'h0, -1, rd);
    chk("oor_alias_intact", rd, 32'hCAFEF00D);

    contend(0, 8, 100);
    contend(0, 40, 60);
    contend(1, 8, 100);
    contend(1, 30, 60);

    txn(1, 1, 1'b1, 8'h33, 32'h0BADCAFE, 4'hF, 2, rd);
    txn(1, 0, 1'b0, 8'h33, 32'h0, 4'h0, 2, rd);
    chk("withdrawn_read", rd, 32'h0BADCAFE);

    txn(1, 1, 1'b1, 8'h22, 32'h01020304, 4'hF, -1, rd);
    @(posedge clk); #1;
    drive(1, 1, 1'b1, 1'b1, 8'h22, 32'hFFFFFFFF, 4'hF);
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", 32'(get_busy(1)), 32'd1);
    rst_b = 1'b1;
    #1;
    chk("reset_abort_busy", 32'(get_busy(1)), 32'd0);
    drive_req(1, 1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v = get_valid(1);
      chk("reset_abort_valid", 32'(v), 32'd0);
    end
    rst_b = 1'b0;
    last_rd_m[1] = 32'h0;
    txn(1, 0, 1'b0, 8'h22, 32'h0, 4'h0, -1, rd);
    chk("reset_abort_word", rd, 32'h01020304);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
